// File: rtl/board_writer_pkg.sv
// Shared types, constants and deal helpers for the two-row card board.
package board_writer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEAL,
    PLAY,
    WRITE,
    CHECK,
    OVER
  } state_t;

  localparam int CARD_W    = 4;
  localparam int NUM_MAX   = 5;
  localparam int ROW1_BASE = 20;
  localparam int VALUE_MAX = 9;
  localparam int ROW_W     = NUM_MAX * CARD_W;
  localparam int STATUS_W  = 2 * ROW_W;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic logic [2:0] eff_num(input logic [2:0] n);
    return (n == 3'd0 || n > 3'(NUM_MAX)) ? 3'(NUM_MAX) : n;
  endfunction

  // Fixed deal: column k holds k+1 while active, zero otherwise.
  function automatic logic [ROW_W-1:0] deal_row(input logic [2:0] n);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_MAX; k++)
      if (k < int'(n))
        r[k*CARD_W +: CARD_W] = CARD_W'(k + 1);
    return r;
  endfunction

endpackage

// File: rtl/board_writer_deal_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, for random deals.
module deal_lfsr
  import board_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] rnd
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign rnd = lfsr_q[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[6:0], fb};
  end

endmodule

// File: rtl/board_writer.sv
// Two-row card board: deal, validated moves, per-move win check.
// Build option RANDOM_DEAL_EN deals LFSR cards over ten cycles.
module board_writer
  import board_writer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          num,
  input  logic                move_valid,
  input  logic [4:0]          move_index,
  input  logic [3:0]          move_value,
  output logic [STATUS_W-1:0] status,
  output logic                player,
  output logic                move_ready,
  output logic                move_err,
  output logic                game_over,
  output logic                winner
);

  state_t state_q, state_d;

  logic [STATUS_W-1:0] status_q;
  logic [STATUS_W-1:0] deal_word;
  logic [2:0]          num_q;
  logic                player_q;
  logic                winner_q;
  logic                err_q;

  logic                accept;
  logic                reject;
  logic                legal;
  logic                deal_done;
  logic                row_clear;
  logic                row_sel;
  logic [4:0]          col_off;
  logic [2:0]          col;
  logic [5:0]          wr_pos;

  always_comb begin
    row_sel = move_index >= 5'(ROW1_BASE);
    col_off = row_sel ? move_index - 5'(ROW1_BASE)
                      : move_index;
    col     = 3'(col_off >> 2);
    wr_pos  = {1'b0, move_index};
    legal   = (move_index[1:0] == 2'b00)
           && (wr_pos <= 6'(ROW1_BASE + 16))
           && (col < num_q)
           && (row_sel == player_q)
           && (move_value <= 4'(VALUE_MAX));
  end

  // Inactive cards are always zero, so the whole row stands in.
  assign row_clear = player_q
    ? (status_q[STATUS_W-1:ROW1_BASE] == '0)
    : (status_q[ROW_W-1:0] == '0);

`ifdef RANDOM_DEAL_EN
  logic [3:0] cnt_q;
  logic [3:0] rnd;
  logic [2:0] dcol;
  logic [3:0] card;

  deal_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .rnd   (rnd)
  );

  always_comb begin
    dcol = (cnt_q >= 4'(NUM_MAX))
         ? 3'(cnt_q - 4'(NUM_MAX))
         : cnt_q[2:0];
    card = (dcol < num_q) ? (rnd % 4'd9) + 4'd1 : '0;
    deal_word = status_q;
    deal_word[{cnt_q, 2'b00} +: CARD_W] = card;
    deal_done = cnt_q == 4'(2 * NUM_MAX - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt_q <= '0;
    else if (start)           cnt_q <= '0;
    else if (state_q == DEAL) cnt_q <= cnt_q + 4'd1;
  end
`else
  always_comb begin
    deal_word = {deal_row(num_q), deal_row(num_q)};
    deal_done = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    if (start) begin
      state_d = DEAL;
    end else begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        DEAL:  if (deal_done) state_d = PLAY;
        PLAY: begin
          if (move_valid) begin
            if (legal) begin
              accept  = 1'b1;
              state_d = WRITE;
            end else begin
              reject  = 1'b1;
            end
          end
        end
        WRITE: state_d = CHECK;
        CHECK: state_d = row_clear ? OVER : PLAY;
        OVER:  state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      num_q    <= 3'(NUM_MAX);
      player_q <= 1'b0;
      winner_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= reject;
      if (start) begin
        num_q    <= eff_num(num);
        player_q <= 1'b0;
        winner_q <= 1'b0;
      end else if (state_q == DEAL) begin
        status_q <= deal_word;
      end else if (accept) begin
        status_q[wr_pos +: CARD_W] <= move_value;
      end else if (state_q == CHECK) begin
        if (row_clear) winner_q <= player_q;
        else           player_q <= ~player_q;
      end
    end
  end

  // The result is known in CHECK, one cycle before OVER is entered.
  assign status     = status_q;
  assign player     = player_q;
  assign move_ready = state_q == PLAY;
  assign move_err   = err_q;
  assign game_over  = (state_q == OVER)
                   || (state_q == CHECK && row_clear);
  assign winner     = (state_q == OVER) ? winner_q
                                        : (game_over & player_q);

endmodule

// File: tb/tb_board_writer.sv
// Scoreboard bench for board_writer, default (fixed-deal) build.
module tb_board_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  num = 3'd0;
  logic        move_valid = 1'b0;
  logic [4:0]  move_index = 5'd0;
  logic [3:0]  move_value = 4'd0;
  logic [39:0] status;
  logic        player;
  logic        move_ready;
  logic        move_err;
  logic        game_over;
  logic        winner;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [39:0] st;
    logic        pl;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [39:0] m_st;
  logic        m_pl;
  int          m_num;

  always #5 clk = ~clk;

  board_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num        (num),
    .move_valid (move_valid),
    .move_index (move_index),
    .move_value (move_value),
    .status     (status),
    .player     (player),
    .move_ready (move_ready),
    .move_err   (move_err),
    .game_over  (game_over),
    .winner     (winner)
  );

  function automatic int eff(input int n);
    return (n == 0 || n > 5) ? 5 : n;
  endfunction

  function automatic logic [39:0] deal_img(input int n);
    logic [39:0] s;
    s = '0;
    for (int k = 0; k < eff(n); k++) begin
      s[k*4 +: 4]      = 4'(k + 1);
      s[20 + k*4 +: 4] = 4'(k + 1);
    end
    return s;
  endfunction

  function automatic bit is_legal(input int idx, input int v);
    return (idx % 4 == 0) && (idx <= 36)
        && ((idx % 20) / 4 < m_num)
        && ((idx >= 20) == m_pl) && (v <= 9);
  endfunction

  task automatic deal(input int n);
    bit seen;
    @(negedge clk);
    start = 1'b1;
    num   = 3'(n);
    @(negedge clk);
    start = 1'b0;
    m_num = eff(n);
    m_st  = deal_img(n);
    m_pl  = 1'b0;
    e.st = m_st; e.pl = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (move_ready) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL deal_timeout: move_ready=%b want 1", move_ready);
    end
  endtask

  // Drive one move for a cycle; returns at the next negedge.
  task automatic send_move(input int idx, input int v);
    bit ok;
    ok = is_legal(idx, v);
    move_valid = 1'b1;
    move_index = 5'(idx);
    move_value = 4'(v);
    if (ok) m_st[idx +: 4] = 4'(v);
    e.st = m_st; e.pl = m_pl; e.err = !ok;
    sb.push_back(e);
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (status !== 40'h0) begin n_fail++;
      $display("FAIL rst_status: got %h want 0", status); end
    n_chk++; if ({player, move_ready, move_err, game_over, winner} !== 5'b0) begin n_fail++;
      $display("FAIL rst_flags: got %b want 00000",
               {player, move_ready, move_err, game_over, winner}); end
    @(negedge clk);
    rst_n = 1'b1;
    move_valid = 1'b1;
    move_index = 5'd4;
    move_value = 4'd3;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    n_chk++; if ({move_ready, move_err, status} !== 42'h0) begin n_fail++;
      $display("FAIL idle_ignore: got %b %b %h want 0 0 0",
               move_ready, move_err, status); end
  endtask

  task automatic test_deal();
    int nums[3] = '{3, 0, 7};
    foreach (nums[i]) begin
      deal(nums[i]);
      e = sb.pop_front();
      n_chk++; if (status !== e.st || player !== e.pl) begin n_fail++;
        $display("FAIL deal_n%0d: got %h/%b want %h/%b",
                 nums[i], status, player, e.st, e.pl); end
    end
  endtask

  task automatic test_move();
    deal(3);
    void'(sb.pop_front());
    send_move(4, 7);
    e = sb.pop_front();
    n_chk++; if (status !== e.st || status[7:4] !== 4'd7) begin n_fail++;
      $display("FAIL move_write: got %h want %h", status, e.st); end
    n_chk++; if (move_err !== e.err || move_ready !== 1'b0) begin n_fail++;
      $display("FAIL move_t1: err=%b rdy=%b want %b 0",
               move_err, move_ready, e.err); end
    @(negedge clk);
    n_chk++; if (player !== 1'b0 || game_over !== 1'b0 || move_err !== 1'b0) begin n_fail++;
      $display("FAIL move_t2: pl=%b go=%b err=%b want 0 0 0",
               player, game_over, move_err); end
    @(negedge clk);
    m_pl = 1'b1;
    n_chk++; if (player !== m_pl || move_ready !== 1'b1 || move_err !== 1'b0) begin n_fail++;
      $display("FAIL move_t3: pl=%b rdy=%b err=%b want 1 1 0",
               player, move_ready, move_err); end
    send_move(24, 5);
    e = sb.pop_front();
    n_chk++; if (status !== e.st || move_err !== e.err) begin n_fail++;
      $display("FAIL move_p1: got %h/%b want %h/%b",
               status, move_err, e.st, e.err); end
    @(negedge clk);
    @(negedge clk);
    m_pl = 1'b0;
    n_chk++; if (player !== m_pl || move_ready !== 1'b1) begin n_fail++;
      $display("FAIL move_p1_turn: pl=%b rdy=%b want 0 1", player, move_ready); end
  endtask

  task automatic test_reject();
    int idx[4] = '{24, 12, 4, 6};
    int val[4] = '{2, 2, 10, 1};
    deal(3);
    void'(sb.pop_front());
    foreach (idx[i]) begin
      send_move(idx[i], val[i]);
      e = sb.pop_front();
      n_chk++; if (move_err !== e.err || e.err !== 1'b1 || status !== e.st) begin n_fail++;
        $display("FAIL reject_%0d: err=%b st=%h want 1 %h",
                 i, move_err, status, e.st); end
      @(negedge clk);
      n_chk++; if (move_err !== 1'b0 || player !== m_pl || move_ready !== 1'b1) begin n_fail++;
        $display("FAIL reject_after_%0d: err=%b pl=%b rdy=%b want 0 %b 1",
                 i, move_err, player, move_ready, m_pl); end
    end
  endtask

  task automatic test_game_over();
    deal(1);
    void'(sb.pop_front());
    send_move(0, 1);
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    m_pl = 1'b1;
    send_move(20, 0);
    e = sb.pop_front();
    n_chk++; if (status !== e.st) begin n_fail++;
      $display("FAIL over1_write: got %h want %h", status, e.st); end
    @(negedge clk);
    n_chk++; if (game_over !== 1'b1 || winner !== 1'b1) begin n_fail++;
      $display("FAIL over1_t2: go=%b win=%b want 1 1", game_over, winner); end
    @(negedge clk);
    n_chk++; if (game_over !== 1'b1 || winner !== 1'b1 || move_ready !== 1'b0) begin n_fail++;
      $display("FAIL over1_hold: go=%b win=%b rdy=%b want 1 1 0",
               game_over, winner, move_ready); end

    deal(1);
    void'(sb.pop_front());
    n_chk++; if (game_over !== 1'b0) begin n_fail++;
      $display("FAIL redeal_clear: go=%b want 0", game_over); end
    send_move(0, 0);
    void'(sb.pop_front());
    @(negedge clk);
    n_chk++; if (game_over !== 1'b1 || winner !== 1'b0) begin n_fail++;
      $display("FAIL over0_t2: go=%b win=%b want 1 0", game_over, winner); end
    @(negedge clk);
    move_valid = 1'b1;
    move_index = 5'd0;
    move_value = 4'd5;
    e.st = m_st; e.pl = m_pl; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    move_valid = 1'b0;
    e = sb.pop_front();
    n_chk++; if (move_err !== e.err || status !== e.st || player !== e.pl) begin n_fail++;
      $display("FAIL over_ignore: err=%b st=%h pl=%b want %b %h %b",
               move_err, status, player, e.err, e.st, e.pl); end
    n_chk++; if (game_over !== 1'b1 || winner !== 1'b0) begin n_fail++;
      $display("FAIL over0_hold: go=%b win=%b want 1 0", game_over, winner); end
    deal(4);
    e = sb.pop_front();
    n_chk++; if (status !== e.st || game_over !== 1'b0) begin n_fail++;
      $display("FAIL over_restart: st=%h go=%b want %h 0",
               status, game_over, e.st); end
  endtask

  task automatic test_reset_write();
    deal(3);
    void'(sb.pop_front());
    send_move(8, 9);
    void'(sb.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (status !== 40'h0 || player !== 1'b0 || move_ready !== 1'b0) begin n_fail++;
      $display("FAIL rst_write: st=%h pl=%b rdy=%b want 0 0 0",
               status, player, move_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (status !== 40'h0 || move_ready !== 1'b0 || game_over !== 1'b0) begin n_fail++;
      $display("FAIL rst_idle: st=%h rdy=%b go=%b want 0 0 0",
               status, move_ready, game_over); end
  endtask

  task automatic test_start_move();
    bit seen;
    deal(3);
    void'(sb.pop_front());
    send_move(4, 7);
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    start      = 1'b1;
    num        = 3'd2;
    move_valid = 1'b1;
    move_index = 5'd24;
    move_value = 4'd0;
    e.st = deal_img(2); e.pl = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    move_valid = 1'b0;
    n_chk++; if (move_err !== 1'b0 || move_ready !== 1'b0) begin n_fail++;
      $display("FAIL start_move_t1: err=%b rdy=%b want 0 0", move_err, move_ready); end
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (move_ready) seen = 1'b1;
      else @(negedge clk);
    end
    e = sb.pop_front();
    n_chk++; if (!seen || status !== e.st || player !== e.pl || move_err !== e.err) begin n_fail++;
      $display("FAIL start_move_deal: rdy=%b st=%h pl=%b err=%b want 1 %h %b %b",
               seen, status, player, move_err, e.st, e.pl, e.err); end
  endtask

  initial begin
    test_reset();
    test_deal();
    test_move();
    test_reject();
    test_game_over();
    test_reset_write();
    test_start_move();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/board_writer.md
BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  one-cycle pulse, deals a new game.
REQ-004 SHALL have port: num  input  3  cards per row, sampled at DEAL entry; 0 or >5 treated as 5.
REQ-005 SHALL have port: move_valid  input  1  one-cycle pulse, move request.
REQ-006 SHALL have port: move_index  input  5  bit offset of target card (0,4,...,36).
REQ-007 SHALL have port: move_value  input  4  new card value, legal 0..9.
REQ-008 SHALL have port: status  output  40  ten 4-bit cards; row 0 = offsets 0..16, row 1 = offsets 20..36.
REQ-009 SHALL have port: player  output  1  side to move (0 owns row 0, 1 owns row 1).
REQ-010 SHALL have port: move_ready  output  1  high only in PLAY.
REQ-011 SHALL have port: move_err  output  1  one-cycle pulse on rejected move.
REQ-012 SHALL have port: game_over  output  1  level, high in OVER.
REQ-013 SHALL have port: winner  output  1  valid while game_over.

Function
REQ-014 SHALL implement FSM states IDLE, DEAL, PLAY, WRITE, CHECK, OVER.
REQ-015 SHALL go IDLE->DEAL on start; start in any state SHALL restart into DEAL (start beats move_valid in the same cycle).
REQ-016 DEAL SHALL write card k (k<num) of each row, zero all cards k>=num, set player=0, then enter PLAY.
REQ-017 In PLAY, move_valid SHALL be accepted only if move_index[1:0]==0, move_index<=36, card column (move_index mod 20)/4 < num, row matches player, and move_value<=9.
REQ-018 Rejected move SHALL pulse move_err the next cycle, leave status/player unchanged, stay in PLAY.
REQ-019 Accepted move in cycle T: status[move_index+:4]=move_value at T+1 (WRITE); CHECK at T+2.
REQ-020 CHECK SHALL test the mover's row: all num active cards zero -> OVER, winner=player; otherwise player toggles, return to PLAY at T+3.
REQ-021 move_valid outside PLAY SHALL be ignored without move_err.
REQ-022 OVER SHALL hold status, player, winner until start or reset.

Reset
REQ-023 On rst_n low, immediately: state IDLE, status=0, player=0, move_ready=0, move_err=0, game_over=0, winner=0; reset mid-WRITE SHALL discard the move.

Configuration
REQ-024 Macro RANDOM_DEAL_EN defined: free-running 8-bit LFSR (seed 8'hA5 at reset, polynomial x^8+x^6+x^5+x^4+1); DEAL lasts 10 cycles, card i (i=0..9) = (lfsr[3:0] mod 9)+1 in cycle i.
REQ-025 Macro undefined: DEAL lasts 1 cycle, card at column k of either row = k+1; no LFSR logic present.

Structure
REQ-026 Shared package SHALL hold the state enum, CARD_W=4, NUM_MAX=5, ROW1_BASE=20, VALUE_MAX=9, LFSR_SEED.
REQ-027 LFSR SHALL be sub-module deal_lfsr, instantiated only under RANDOM_DEAL_EN.

Verification
REQ-028 Macro undefined, num=3, start -> next PLAY cycle status=40'h0_0321_0_0321 in offset order (row0 = 1,2,3,0,0; row1 = 1,2,3,0,0), player=0.
REQ-029 PLAY, player=0, move (index 4, value 7) -> status[7:4]=7 at T+1, player=1 at T+3, move_err never high.
REQ-030 player=0, move (index 24, value 2), then (index 12, value 2) with num=3, then value 10 -> each pulses move_err once, status unchanged.
REQ-031 num=1, player 0 writes 0 at index 0 -> game_over=1, winner=0 at T+2; later move_valid ignored; start -> DEAL.
REQ-032 rst_n low during WRITE cycle -> status=0 and state IDLE immediately, no card updated.
REQ-033 start and move_valid same cycle in PLAY -> re-deal, move discarded, no move_err.
